// File: rtl/game_flow_fsm_if.sv
// Control bundle between the game flow controller and the blocks it sequences.
// The controller uses the master view; the invader/player/score side uses the slave view.
interface game_flow_fsm_if #(
  parameter int LW = 3
);
  logic          frame_tick;
  logic          start_btn;
  logic          pause_btn;
  logic          player_hit;
  logic          wave_cleared;
  logic [2:0]    state;
  logic [LW-1:0] level;
  logic [2:0]    lives;
  logic          blink;
  logic          reset_game;
  logic          next_wave;

  modport master (
    input  frame_tick, start_btn, pause_btn, player_hit, wave_cleared,
    output state, level, lives, blink, reset_game, next_wave
  );

  modport slave (
    output frame_tick, start_btn, pause_btn, player_hit, wave_cleared,
    input  state, level, lives, blink, reset_game, next_wave
  );
endinterface

// File: rtl/game_flow_fsm.sv
// Top-level game flow controller: menu, play, pause, inter-wave clear, game over and win,
// stepped once per frame strobe, with debounced start/pause buttons.
module game_flow_fsm #(
  parameter int BLINK_BITS      = 6,
  parameter int LIVES           = 3,
  parameter int LEVELS          = 8,
  parameter int CLEAR_FRAMES    = 90,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  game_flow_fsm_if.master bus
);

  localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam int TW = (CLEAR_FRAMES > 1) ? $clog2(CLEAR_FRAMES) : 1;
  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);

  localparam logic [DW-1:0] DB_MAX     = DW'(DEBOUNCE_FRAMES);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_FRAMES - 1);
  localparam logic [2:0]    LIVES_INIT = 3'(LIVES);
  localparam logic [LW-1:0] LEVEL_LAST = LW'(LEVELS - 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(CLEAR_FRAMES - 1);

  typedef enum logic [2:0] {
    ST_MENU  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_PAUSE = 3'd2,
    ST_CLEAR = 3'd3,
    ST_OVER  = 3'd4,
    ST_WIN   = 3'd5
  } state_t;

  state_t                state_q;
  logic [LW-1:0]         level_q;
  logic [2:0]            lives_q;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic                  reset_game_q;
  logic                  next_wave_q;
  logic [DW-1:0]         start_cnt;
  logic [DW-1:0]         pause_cnt;
  logic [TW-1:0]         timer_q;
  logic                  start_press;
  logic                  pause_press;

  // A press is the single tick on which a held button's count reaches the threshold;
  // the counter then saturates so a long hold cannot fire again.
  always_comb begin
    start_press = bus.start_btn && (start_cnt == DB_LAST);
    pause_press = bus.pause_btn && (pause_cnt == DB_LAST);
  end

  // NOTE: all state is updated with non-blocking assignments so every branch below
  // reads the pre-edge values, exactly like the flops it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_MENU;
      level_q      <= '0;
      lives_q      <= LIVES_INIT;
      blink_cnt    <= '0;
      reset_game_q <= 1'b0;
      next_wave_q  <= 1'b0;
      start_cnt    <= '0;
      pause_cnt    <= '0;
      timer_q      <= '0;
    end else begin
      // NOTE: pulses default low on every clk so they last one cycle even though
      // the rest of the state only moves on frame ticks.
      reset_game_q <= 1'b0;
      next_wave_q  <= 1'b0;

      if (bus.frame_tick) begin
        blink_cnt <= blink_cnt + 1'b1;

        if (!bus.start_btn)        start_cnt <= '0;
        else if (start_cnt != DB_MAX) start_cnt <= start_cnt + 1'b1;

        if (!bus.pause_btn)        pause_cnt <= '0;
        else if (pause_cnt != DB_MAX) pause_cnt <= pause_cnt + 1'b1;

        case (state_q)
          ST_MENU: begin
            if (start_press) begin
              state_q      <= ST_PLAY;
              reset_game_q <= 1'b1;
              level_q      <= '0;
              lives_q      <= LIVES_INIT;
            end
          end

          ST_PLAY: begin
            if (bus.player_hit) begin
              if (lives_q <= 3'd1) begin
                state_q <= ST_OVER;
                lives_q <= '0;
              end else begin
                lives_q <= lives_q - 1'b1;
              end
            end else if (bus.wave_cleared) begin
              state_q <= ST_CLEAR;
              timer_q <= TIMER_LOAD;
            end else if (pause_press) begin
              state_q <= ST_PAUSE;
            end
          end

          ST_PAUSE: begin
            if (pause_press) state_q <= ST_PLAY;
          end

          ST_CLEAR: begin
            if (timer_q == '0) begin
              if (level_q >= LEVEL_LAST) begin
                state_q <= ST_WIN;
              end else begin
                state_q     <= ST_PLAY;
                level_q     <= level_q + 1'b1;
                next_wave_q <= 1'b1;
              end
            end else begin
              timer_q <= timer_q - 1'b1;
            end
          end

          ST_OVER, ST_WIN: begin
            if (start_press) begin
              state_q      <= ST_MENU;
              reset_game_q <= 1'b1;
              level_q      <= '0;
              lives_q      <= LIVES_INIT;
            end
          end

          default: state_q <= ST_MENU;
        endcase
      end
    end
  end

  assign bus.state      = state_q;
  assign bus.level      = level_q;
  assign bus.lives      = lives_q;
  assign bus.blink      = blink_cnt[BLINK_BITS-1];
  assign bus.reset_game = reset_game_q;
  assign bus.next_wave  = next_wave_q;

endmodule

// File: tb/tb_game_flow_fsm.sv
// Directed bench for game_flow_fsm: a default build and a two-wave build share one
// stimulus stream; expected values are hand-computed per step.
module tb_game_flow_fsm;

  logic clk;
  logic rst_n;
  logic frame_tick;
  logic start_btn;
  logic pause_btn;
  logic player_hit;
  logic wave_cleared;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ticks  = 0;
  int rg_a     = 0;
  int nw_a     = 0;
  int nw_b     = 0;
  int rg_base;
  int nw_base;

  game_flow_fsm_if #(.LW(3)) bus_a ();
  game_flow_fsm_if #(.LW(1)) bus_b ();

  assign bus_a.frame_tick   = frame_tick;
  assign bus_a.start_btn    = start_btn;
  assign bus_a.pause_btn    = pause_btn;
  assign bus_a.player_hit   = player_hit;
  assign bus_a.wave_cleared = wave_cleared;
  assign bus_b.frame_tick   = frame_tick;
  assign bus_b.start_btn    = start_btn;
  assign bus_b.pause_btn    = pause_btn;
  assign bus_b.player_hit   = player_hit;
  assign bus_b.wave_cleared = wave_cleared;

  game_flow_fsm #(
    .BLINK_BITS(6), .LIVES(3), .LEVELS(8), .CLEAR_FRAMES(90), .DEBOUNCE_FRAMES(3)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  game_flow_fsm #(
    .BLINK_BITS(6), .LIVES(3), .LEVELS(2), .CLEAR_FRAMES(4), .DEBOUNCE_FRAMES(3)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sample on the rising edge, i.e. the value held during the previous cycle.
  always @(posedge clk) begin
    if (bus_a.reset_game) rg_a++;
    if (bus_a.next_wave)  nw_a++;
    if (bus_b.next_wave)  nw_b++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One frame: inputs and strobe for one clk, then one idle clk so any pulse has come and gone.
  task automatic tick(input logic s, input logic p, input logic h, input logic w);
    @(negedge clk);
    start_btn    = s;
    pause_btn    = p;
    player_hit   = h;
    wave_cleared = w;
    frame_tick   = 1'b1;
    @(negedge clk);
    frame_tick   = 1'b0;
    @(negedge clk);
    n_ticks++;
  endtask

  initial begin
    rst_n        = 1'b0;
    frame_tick   = 1'b0;
    start_btn    = 1'b1;
    pause_btn    = 1'b0;
    player_hit   = 1'b0;
    wave_cleared = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_state", int'(bus_a.state), 0);
    check("rst_level", int'(bus_a.level), 0);
    check("rst_lives", int'(bus_a.lives), 3);
    check("rst_blink", int'(bus_a.blink), 0);
    check("rst_reset_game", int'(bus_a.reset_game), 0);
    check("rst_next_wave", int'(bus_a.next_wave), 0);

    // Start held through reset: event on the third tick after release.
    rst_n = 1'b1;
    rg_base = rg_a;
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    check("start_tick2_state", int'(bus_a.state), 0);
    tick(1, 0, 0, 0);
    check("start_tick3_state", int'(bus_a.state), 1);
    check("start_lives", int'(bus_a.lives), 3);
    check("start_level", int'(bus_a.level), 0);
    check("start_reset_pulses", rg_a - rg_base, 1);
    check("pulse_dropped", int'(bus_a.reset_game), 0);
    repeat (10) tick(1, 0, 0, 0);
    check("hold_state", int'(bus_a.state), 1);
    check("hold_reset_pulses", rg_a - rg_base, 1);
    tick(0, 0, 0, 0);

    // Lose all lives.
    tick(0, 0, 1, 0);
    check("hit1_lives", int'(bus_a.lives), 2);
    tick(0, 0, 1, 0);
    check("hit2_lives", int'(bus_a.lives), 1);
    check("hit2_state", int'(bus_a.state), 1);
    tick(0, 0, 1, 0);
    check("hit3_state", int'(bus_a.state), 4);
    check("hit3_lives", int'(bus_a.lives), 0);
    tick(0, 0, 1, 0);
    check("over_no_underflow", int'(bus_a.lives), 0);
    check("over_hold_state", int'(bus_a.state), 4);

    rg_base = rg_a;
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    check("over_start_early", int'(bus_a.state), 4);
    tick(1, 0, 0, 0);
    check("over_to_menu", int'(bus_a.state), 0);
    check("over_reset_pulse", rg_a - rg_base, 1);
    tick(0, 0, 0, 0);

    // New game, hit beats clear, then one full clear interval.
    repeat (3) tick(1, 0, 0, 0);
    check("restart_state", int'(bus_a.state), 1);
    check("restart_lives", int'(bus_a.lives), 3);
    tick(0, 0, 1, 1);
    check("prio_lives", int'(bus_a.lives), 2);
    check("prio_state", int'(bus_a.state), 1);
    tick(0, 0, 0, 1);
    check("clear_enter", int'(bus_a.state), 3);
    nw_base = nw_a;
    for (int i = 1; i <= 89; i++) tick(0, (i <= 5), (i <= 5), 0);
    check("clear_89_state", int'(bus_a.state), 3);
    check("clear_hit_ignored", int'(bus_a.lives), 2);
    check("clear_89_level", int'(bus_a.level), 0);
    tick(0, 0, 0, 0);
    check("clear_90_state", int'(bus_a.state), 1);
    check("clear_90_level", int'(bus_a.level), 1);
    check("clear_next_wave", nw_a - nw_base, 1);

    // Pause freezes play.
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    check("pause_early", int'(bus_a.state), 1);
    tick(0, 1, 0, 0);
    check("pause_enter", int'(bus_a.state), 2);
    tick(0, 0, 1, 1);
    check("pause_state_hold", int'(bus_a.state), 2);
    check("pause_lives_hold", int'(bus_a.lives), 2);
    check("pause_level_hold", int'(bus_a.level), 1);
    repeat (3) tick(0, 1, 0, 0);
    check("pause_exit", int'(bus_a.state), 1);
    tick(0, 0, 0, 0);

    // Async reset while in CLEAR, between ticks.
    tick(0, 0, 0, 1);
    check("clear2_enter", int'(bus_a.state), 3);
    repeat (3) tick(0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_state", int'(bus_a.state), 0);
    check("async_level", int'(bus_a.level), 0);
    check("async_lives", int'(bus_a.lives), 3);
    check("async_blink", int'(bus_a.blink), 0);
    check("async_reset_game", int'(bus_a.reset_game), 0);
    check("async_next_wave", int'(bus_a.next_wave), 0);
    @(negedge clk);
    rst_n   = 1'b1;
    n_ticks = 0;

    // Two-wave build: clear both waves, win without a next_wave pulse.
    repeat (3) tick(1, 0, 0, 0);
    check("b_play", int'(bus_b.state), 1);
    tick(0, 0, 0, 1);
    check("b_clear1", int'(bus_b.state), 3);
    nw_base = nw_b;
    repeat (3) tick(0, 0, 0, 0);
    check("b_clear1_hold", int'(bus_b.state), 3);
    tick(0, 0, 0, 0);
    check("b_wave1_state", int'(bus_b.state), 1);
    check("b_wave1_level", int'(bus_b.level), 1);
    check("b_wave1_pulse", nw_b - nw_base, 1);
    tick(0, 0, 0, 1);
    check("b_clear2", int'(bus_b.state), 3);
    repeat (4) tick(0, 0, 0, 0);
    check("b_win_state", int'(bus_b.state), 5);
    check("b_win_level", int'(bus_b.level), 1);
    check("b_win_no_pulse", nw_b - nw_base, 1);

    // Blink MSB of a 6-bit frame counter toggles every 32 ticks.
    while (n_ticks < 31) tick(0, 0, 0, 0);
    check("blink_31", int'(bus_a.blink), 0);
    tick(0, 0, 0, 0);
    check("blink_32", int'(bus_a.blink), 1);
    while (n_ticks < 63) tick(0, 0, 0, 0);
    check("blink_63", int'(bus_a.blink), 1);
    tick(0, 0, 0, 0);
    check("blink_64", int'(bus_a.blink), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
